// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: FSM states, sample offsets and parity-type constants shared by the UART receiver (PARITY state only with RX_PARITY_EN)
package uart_rx_pkg;
`ifdef RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
    function automatic int samp_lo(input int prescale);
        return prescale / 2 - 1;
    endfunction
    function automatic int samp_mid(input int prescale);
        return prescale / 2;
    endfunction
    function automatic int samp_hi(input int prescale);
        return prescale / 2 + 1;
    endfunction
endpackage

// File: rtl/uart_rx_deserializer_sampler.sv
// rx_data_sampler: per-bit edge counter with three-point majority vote around mid-bit
module rx_data_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_in,
    input  logic run,
    output logic sampled_bit,
    output logic sample_done,
    output logic bit_end
);
    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LO   = CW'(samp_lo(PRESCALE));
    localparam logic [CW-1:0] MID  = CW'(samp_mid(PRESCALE));
    localparam logic [CW-1:0] HI   = CW'(samp_hi(PRESCALE));
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
    logic [CW-1:0] edge_cnt_q, edge_cnt_d;
    logic s_lo_q, s_lo_d, s_mid_q, s_mid_d;
    // Counter follows the frame only while the FSM is active; the third sample is the live line at H+1
    always_comb begin
        bit_end     = edge_cnt_q == LAST;
        sample_done = edge_cnt_q == HI;
        edge_cnt_d  = run ? (bit_end ? '0 : edge_cnt_q + CW'(1)) : '0;
        s_lo_d      = edge_cnt_q == LO ? rx_in : s_lo_q;
        s_mid_d     = edge_cnt_q == MID ? rx_in : s_mid_q;
        sampled_bit = (s_lo_q & s_mid_q) | (s_lo_q & rx_in) | (s_mid_q & rx_in);
    end
    // Counter and sample registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt_q <= '0;
            s_lo_q     <= 1'b0;
            s_mid_q    <= 1'b0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            s_lo_q     <= s_lo_d;
            s_mid_q    <= s_mid_d;
        end
    end
endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: oversampling UART receiver, MSB first, registered outputs; RX_PARITY_EN adds a parity bit and Par_Err
module uart_rx_deserializer
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_Data,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err,
    output logic                  Busy
);
    localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
`ifdef RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
    logic par_bit_q, par_bit_d;
`else
    localparam state_t AFTER_DATA = STOP;
    logic par_typ_unused;
    assign par_typ_unused = PAR_TYP;
`endif
    state_t state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, p_data_q, p_data_d;
    logic data_valid_q, data_valid_d, par_err_q, par_err_d, stp_err_q, stp_err_d, busy_q, busy_d;
    logic par_bad, sampled_bit, sample_done, bit_end;

    rx_data_sampler #(.PRESCALE(PRESCALE)) u_sampler (
        .clk         (CLK),
        .rst         (RST),
        .rx_in       (RX_IN),
        .run         (state_d != IDLE),
        .sampled_bit (sampled_bit),
        .sample_done (sample_done),
        .bit_end     (bit_end)
    );

    // Frame FSM; STOP returns to IDLE at the decision point so a following start edge costs no cycles
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
`ifdef RX_PARITY_EN
        par_bit_d    = par_bit_q;
        par_bad      = (^shift_q ^ (PAR_TYP == PAR_ODD)) != par_bit_q;
`else
        par_bad      = 1'b0;
`endif
        case (state_q)
            IDLE: state_d = RX_IN ? IDLE : START;
            START: begin
                bit_cnt_d = '0;
                if (sample_done && sampled_bit) state_d = IDLE;
                else if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (sample_done) shift_d = {shift_q[DATA_WIDTH-2:0], sampled_bit};
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == LAST_BIT) state_d = AFTER_DATA;
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (sample_done) par_bit_d = sampled_bit;
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: if (sample_done) begin
                state_d      = IDLE;
                stp_err_d    = !sampled_bit;
                par_err_d    = par_bad;
                data_valid_d = sampled_bit && !par_bad;
                p_data_d     = data_valid_d ? shift_q : p_data_q;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    // State, datapath and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef RX_PARITY_EN
            par_bit_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
            busy_q       <= busy_d;
`ifdef RX_PARITY_EN
            par_bit_q    <= par_bit_d;
`endif
        end
    end

    assign P_Data     = p_data_q;
    assign Data_Valid = data_valid_q;
    assign Par_Err    = par_err_q;
    assign Stp_Err    = stp_err_q;
    assign Busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: directed vector table plus hand-written glitch, reset and back-to-back sequences
module tb_uart_rx_deserializer;
    localparam int PS = 8;
`ifdef RX_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    localparam int LAT   = NB * PS + PS / 2 + 2;
    localparam int FRAME = (NB + 1) * PS;

    logic CLK = 1'b0, RST = 1'b1, RX_IN = 1'b1, PAR_TYP = 1'b0;
    logic [7:0] P_Data;
    logic Data_Valid, Par_Err, Stp_Err, Busy;
    int cyc = 0, checks = 0, errors = 0, t0, t1;
    int dv_cyc[$], se_cyc[$], pe_cyc[$];
    logic [7:0] dv_dat[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        bit         noise;
        logic       exp_dv;
        logic       exp_se;
        logic [7:0] exp_pd;
    } vec_t;
    vec_t vecs[6];

    uart_rx_deserializer #(.PRESCALE(PS), .DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_TYP    (PAR_TYP),
        .P_Data     (P_Data),
        .Data_Valid (Data_Valid),
        .Par_Err    (Par_Err),
        .Stp_Err    (Stp_Err),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (Data_Valid) begin
            dv_cyc.push_back(cyc);
            dv_dat.push_back(P_Data);
        end
        if (Stp_Err) se_cyc.push_back(cyc);
        if (Par_Err) pe_cyc.push_back(cyc);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear();
        dv_cyc.delete();
        dv_dat.delete();
        se_cyc.delete();
        pe_cyc.delete();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, input bit noise, output int start);
        logic v;
        start = cyc;
        for (int i = 0; i <= NB; i++) begin
            v = (i == 0) ? 1'b0 : (i <= 8) ? d[8 - i] : (i == NB) ? stop : par;
            for (int e = 0; e < PS; e++) begin
                RX_IN = (noise && i >= 1 && i <= 8 && e == 3) ? ~v : v;
                @(negedge CLK);
            end
        end
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
        vecs[1] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
        vecs[2] = '{8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, 8'hC3};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF};
        vecs[5] = '{8'h96, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF};
        repeat (3) @(negedge CLK);
        chk("rst_pdata", P_Data, 0);
        chk("rst_dv", Data_Valid, 0);
        chk("rst_pe", Par_Err, 0);
        chk("rst_se", Stp_Err, 0);
        chk("rst_busy", Busy, 0);
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        for (int i = 0; i < 6; i++) begin
            clear();
            send_frame(vecs[i].data, vecs[i].stop, ^vecs[i].data, vecs[i].noise, t0);
            RX_IN = 1'b1;
            repeat (16) @(negedge CLK);
            chk($sformatf("v%0d_dv_count", i), dv_cyc.size(), vecs[i].exp_dv);
            chk($sformatf("v%0d_se_count", i), se_cyc.size(), vecs[i].exp_se);
            chk($sformatf("v%0d_pe_count", i), pe_cyc.size(), 0);
            chk($sformatf("v%0d_pdata", i), P_Data, vecs[i].exp_pd);
            if (vecs[i].exp_dv) chk($sformatf("v%0d_dv_cycle", i), dv_cyc.size() > 0 ? dv_cyc[0] - t0 : -1, LAT);
            if (vecs[i].exp_se) chk($sformatf("v%0d_se_cycle", i), se_cyc.size() > 0 ? se_cyc[0] - t0 : -1, LAT);
        end
        clear();
        RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (3) @(negedge CLK);
        chk("glitch_busy_c5", Busy, 1);
        @(negedge CLK);
        chk("glitch_busy_c6", Busy, 0);
        repeat (10) @(negedge CLK);
        chk("glitch_no_pulse", dv_cyc.size() + se_cyc.size() + pe_cyc.size(), 0);
        send_frame(8'h3C, 1'b1, ^8'h3C, 1'b0, t0);
        repeat (4) @(negedge CLK);
        chk("after_glitch_dv", dv_cyc.size(), 1);
        chk("after_glitch_pdata", P_Data, 8'h3C);
`ifdef RX_PARITY_EN
        clear();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, t0);
        repeat (4) @(negedge CLK);
        chk("par_err_count", pe_cyc.size(), 1);
        chk("par_err_cycle", pe_cyc.size() > 0 ? pe_cyc[0] - t0 : -1, LAT);
        chk("par_err_no_dv", dv_cyc.size(), 0);
        clear();
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, t0);
        repeat (4) @(negedge CLK);
        chk("par_ok_dv", dv_cyc.size(), 1);
        chk("par_ok_pe", pe_cyc.size(), 0);
        chk("par_ok_pdata", P_Data, 8'h3C);
`endif
        clear();
        RX_IN = 1'b0;
        repeat (PS) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (12) @(negedge CLK);
        chk("mid_busy", Busy, 1);
        RST = 1'b1;
        #1;
        chk("mid_rst_pdata", P_Data, 0);
        chk("mid_rst_busy", Busy, 0);
        chk("mid_rst_dv", Data_Valid, 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        chk("mid_rst_no_pulse", dv_cyc.size() + se_cyc.size() + pe_cyc.size(), 0);
        clear();
        send_frame(8'h01, 1'b1, ^8'h01, 1'b0, t0);
        send_frame(8'hFE, 1'b1, ^8'hFE, 1'b0, t1);
        repeat (4) @(negedge CLK);
        chk("b2b_count", dv_cyc.size(), 2);
        chk("b2b_first_cycle", dv_cyc.size() == 2 ? dv_cyc[0] - t0 : -1, LAT);
        chk("b2b_gap", dv_cyc.size() == 2 ? dv_cyc[1] - dv_cyc[0] : -1, FRAME);
        chk("b2b_first_data", dv_dat.size() == 2 ? dv_dat[0] : 8'hXX, 8'h01);
        chk("b2b_second_data", dv_dat.size() == 2 ? dv_dat[1] : 8'hXX, 8'hFE);
        chk("b2b_no_err", se_cyc.size() + pe_cyc.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Receive-side counterpart of the UART_TX serializer. It oversamples the serial line, detects the start bit, majority-votes each bit, shifts 8 data bits into a parallel word, checks the stop bit, and presents the word with a one-cycle valid pulse. It sits between the line input of UART_RX and the consumer of received bytes. Bit order is MSB first, matching the transmitter, which shifts out bit 7 first.

## Interface
- PRESCALE, default 8: clock cycles per bit. Legal values are 8, 16 and 32.
- DATA_WIDTH, default 8: data bits per frame.
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- RX_IN  in  1  serial line, idle high. It is already synchronized to CLK upstream.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity. Used only with RX_PARITY_EN.
- P_Data  out  DATA_WIDTH  last good received word. Reset value 0.
- Data_Valid  out  1  one-cycle pulse when P_Data is updated. Reset value 0.
- Par_Err  out  1  one-cycle pulse on parity mismatch. Reset value 0.
- Stp_Err  out  1  one-cycle pulse when the stop bit is sampled low. Reset value 0.
- Busy  out  1  high in any state other than IDLE. Reset value 0.

## Operation
- FSM states: IDLE, START, DATA, PARITY (only with RX_PARITY_EN), STOP.
- Edge counter runs 0..PRESCALE-1 and wraps at each bit boundary.
- Bit counter runs 0..DATA_WIDTH-1 and is used only in DATA.
- IDLE: when RX_IN is 0, go to START with edge counter = 0. This cycle is cycle 0 of the frame.
- Sampling: RX_IN is captured at edge counts H-1, H and H+1, where H = PRESCALE/2. The bit value is the 2-of-3 majority, decided at edge count H+1.
- START: if the start decision is 1, the start was a glitch.
  - Return to IDLE in the next cycle.
  - No outputs pulse.
  - Otherwise advance to DATA at the bit boundary.
- DATA: each decided bit shifts into an internal shift register from the LSB side. The first received bit ends up in bit DATA_WIDTH-1.
  - After bit DATA_WIDTH-1, go to PARITY, or to STOP when parity is compiled out.
- STOP: act on the stop decision at edge count H+1.
  - The following cycle is one of:
    - Data_Valid = 1 with P_Data = shift register, when stop = 1 and there is no parity error.
    - Stp_Err = 1, when stop = 0.
    - Par_Err = 1, on a parity mismatch.
  - Par_Err and Stp_Err may pulse together.
  - On any error, P_Data keeps its previous value.
- STOP goes to IDLE at the decision point, not at the end of the bit. RX_IN is still high for the rest of the stop bit, so no false start can occur. A start edge arriving after that point is accepted with no dead cycles.
- Reset mid-frame: all state, counters and outputs clear immediately. The partial frame is discarded.

## Timing
- Let N = 1 + DATA_WIDTH + P, where P = 1 with parity and 0 without.
- Stop decision at cycle N·PRESCALE + H + 1.
- Data_Valid high at cycle N·PRESCALE + H + 2.
  - PRESCALE=8, no parity: Data_Valid at cycle 78.
  - PRESCALE=8, with parity: Data_Valid at cycle 86.
- Glitch reject: Busy deasserts at cycle H+2.
- All outputs are registered. There is no combinational path from RX_IN to any output.

## Configuration
- RX_PARITY_EN defined:
  - The frame carries a parity bit after the data bits.
  - The PARITY state exists.
  - Expected parity = XOR of the data bits, inverted when PAR_TYP = 1.
  - A mismatch raises Par_Err in the same cycle as the stop outcome.
- RX_PARITY_EN undefined:
  - No parity bit and no PARITY state.
  - PAR_TYP is ignored.
  - Par_Err is tied to 0.

## Structure
- Shared package uart_rx_pkg holds:
  - the state enum;
  - sampling offset constants H-1, H and H+1, derived from PRESCALE;
  - the PAR_EVEN and PAR_ODD constants.
- Sub-module rx_data_sampler owns:
  - the edge counter;
  - the three sample registers;
  - the majority vote.
- rx_data_sampler outputs sampled_bit, sample_done (high at edge count H+1) and bit_end (high at edge count PRESCALE-1).
- The top module holds the FSM, bit counter, shift register, parity check and output registers.

## Test plan
- Clean frame: PRESCALE=8, no parity, send 0xA5 with stop = 1 → Data_Valid pulses at cycle 78, P_Data = 0xA5, both error outputs stay 0.
- Start glitch: RX_IN low for 2 cycles, then high → no output pulses, Busy falls at cycle 6, next frame 0x3C is received correctly.
- Bad stop: send 0x5A with stop = 0 → Stp_Err pulses at cycle 78, Data_Valid stays 0, P_Data keeps its previous value.
- Parity (RX_PARITY_EN, PAR_TYP=0): send 0x3C with parity bit 1 → Par_Err pulses at cycle 86.
  - Resend with parity bit 0 → Data_Valid pulses and P_Data = 0x3C.
- Noise: flip one of the three samples (edge count 3) on every data bit of 0xC3 → P_Data = 0xC3 with no errors.
- Reset and back-to-back frames: assert RST in the middle of the DATA state → all outputs drop to 0 immediately. Then send 0x01 and 0xFE back to back with a single stop bit each → two Data_Valid pulses exactly 80 cycles apart (one full frame at PRESCALE=8, no parity).
